// File: rtl/cpu_trace_monitor_if.sv
// rtl/cpu_trace_monitor_if.sv - retire input channel and trace output channel of the trace monitor
interface cpu_trace_monitor_if #(
   parameter int XLEN = 64
);
   logic            retire_valid;
   logic [63:0]     retire_pc;
   logic [31:0]     retire_instr;
   logic [4:0]      retire_rd;
   logic            retire_reg_write;
   logic [XLEN-1:0] retire_wdata;

   logic            trace_valid;
   logic            trace_ready;
   logic [63:0]     trace_pc;
   logic [31:0]     trace_instr;
   logic [4:0]      trace_rd;
   logic [XLEN-1:0] trace_wdata;

   modport slave (
      input  retire_valid, retire_pc, retire_instr, retire_rd, retire_reg_write, retire_wdata,
      input  trace_ready,
      output trace_valid, trace_pc, trace_instr, trace_rd, trace_wdata
   );

   modport master (
      output retire_valid, retire_pc, retire_instr, retire_rd, retire_reg_write, retire_wdata,
      output trace_ready,
      input  trace_valid, trace_pc, trace_instr, trace_rd, trace_wdata
   );
endinterface

// File: rtl/cpu_trace_monitor.sv
// rtl/cpu_trace_monitor.sv - retire trace FIFO with halt detection; optional watchdog via TRACE_WATCHDOG_EN
module cpu_trace_monitor #(
   parameter int XLEN        = 64,
   parameter int DEPTH       = 8,
   parameter int WDOG_CYCLES = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   cpu_trace_monitor_if.slave       bus,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [31:0]              instr_count,
   output logic [15:0]              drop_count,
   output logic                     halted,
   output logic                     timeout
);
   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WDOG_CYCLES < 1) begin : g_param_check
      $error("cpu_trace_monitor: DEPTH must be a power of two >= 2 and WDOG_CYCLES >= 1");
   end

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1
`ifdef TRACE_WATCHDOG_EN
      , ST_TIMEOUT = 2'd2
`endif
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [63:0]     r_pc_mem    [DEPTH];
   logic [31:0]     r_instr_mem [DEPTH];
   logic [4:0]      r_rd_mem    [DEPTH];
   logic [XLEN-1:0] r_wdata_mem [DEPTH];

   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [AW:0]     r_count;
   logic [31:0]     r_instr_cnt;
   logic [15:0]     r_drop_cnt;

   logic            w_run;
   logic            w_retire_run;
   logic            w_halt_nop;
   logic            w_push_try;
   logic            w_full;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;
   logic            w_wdog_expire;
   logic [XLEN-1:0] w_wdata;

   assign w_run        = (r_state == ST_RUN);
   assign w_retire_run = bus.retire_valid && w_run;
   assign w_halt_nop   = w_retire_run && (bus.retire_instr == 32'h0);
   assign w_push_try   = w_retire_run && (bus.retire_instr != 32'h0);
   assign w_full       = (r_count == (AW+1)'(DEPTH));
   assign w_pop        = (r_count != '0) && bus.trace_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push       = w_push_try && (!w_full || w_pop);
   assign w_drop       = w_push_try && w_full && !w_pop;
   assign w_wdata      = (bus.retire_reg_write && bus.retire_rd != 5'd0) ? bus.retire_wdata : '0;

`ifdef TRACE_WATCHDOG_EN
   localparam int IW = $clog2(WDOG_CYCLES + 1);
   logic [IW-1:0] r_idle;
   logic [IW-1:0] w_idle_nxt;

   assign w_idle_nxt    = r_idle + 1'b1;
   assign w_wdog_expire = w_run && !bus.retire_valid && (w_idle_nxt == IW'(WDOG_CYCLES));
   assign timeout       = (r_state == ST_TIMEOUT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idle <= '0;
      end else if (w_run) begin
         r_idle <= bus.retire_valid ? '0 : w_idle_nxt;
      end
   end
`else
   assign w_wdog_expire = 1'b0;
   assign timeout       = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_halt_nop) begin
               w_state_nxt = ST_HALT;
`ifdef TRACE_WATCHDOG_EN
            end else if (w_wdog_expire) begin
               w_state_nxt = ST_TIMEOUT;
`endif
            end
         end
         default: w_state_nxt = r_state;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Storage is deliberately not reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wptr]    <= bus.retire_pc;
         r_instr_mem[r_wptr] <= bus.retire_instr;
         r_rd_mem[r_wptr]    <= bus.retire_rd;
         r_wdata_mem[r_wptr] <= w_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_instr_cnt <= '0;
         r_drop_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_push_try) begin
            r_instr_cnt <= r_instr_cnt + 1'b1;
         end
         if (w_drop && r_drop_cnt != 16'hFFFF) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end
   end

   assign bus.trace_valid = (r_count != '0);
   assign bus.trace_pc    = r_pc_mem[r_rptr];
   assign bus.trace_instr = r_instr_mem[r_rptr];
   assign bus.trace_rd    = r_rd_mem[r_rptr];
   assign bus.trace_wdata = r_wdata_mem[r_rptr];

   assign fifo_count  = r_count;
   assign instr_count = r_instr_cnt;
   assign drop_count  = r_drop_cnt;
   assign halted      = (r_state != ST_RUN);
endmodule

// File: doc/cpu_trace_monitor.md
CPU_TRACE_MONITOR -- requirements
Module: cpu_trace_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 64, retired-result data width.
REQ-002 SHALL have parameter DEPTH, default 8, trace FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter WDOG_CYCLES, default 1024, idle cycles before timeout.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port retire_valid  input  1  one instruction retires this cycle.
REQ-007 SHALL have port retire_pc  input  64  PC of retiring instruction.
REQ-008 SHALL have port retire_instr  input  32  retiring instruction word.
REQ-009 SHALL have port retire_rd  input  5  destination register index.
REQ-010 SHALL have port retire_reg_write  input  1  instruction writes rd.
REQ-011 SHALL have port retire_wdata  input  XLEN  value written to rd.
REQ-012 SHALL have port trace_valid  output  1  FIFO head record available.
REQ-013 SHALL have port trace_ready  input  1  consumer accepts head record.
REQ-014 SHALL have port trace_pc / trace_instr / trace_rd / trace_wdata  output  64/32/5/XLEN  head record fields.
REQ-015 SHALL have port fifo_count  output  $clog2(DEPTH)+1  occupied entries.
REQ-016 SHALL have port instr_count  output  32  retired non-halt instructions.
REQ-017 SHALL have port drop_count  output  16  records lost to full FIFO.
REQ-018 SHALL have port halted  output  1  sticky halt flag.
REQ-019 SHALL have port timeout  output  1  sticky watchdog flag.

Function
REQ-020 Push SHALL occur when retire_valid=1, halted=0, retire_instr!=0; record = {pc, instr, rd, wdata}.
REQ-021 Recorded wdata SHALL be 0 when retire_reg_write=0 or retire_rd=0.
REQ-022 Pop SHALL occur when trace_valid=1 and trace_ready=1; head advances next edge.
REQ-023 trace_valid SHALL equal (fifo_count!=0); head fields SHALL be stable while trace_valid=1 and trace_ready=0.
REQ-024 Push-to-trace_valid latency SHALL be one cycle (record visible the cycle after retire).
REQ-025 Full FIFO with push and no pop: record dropped, drop_count +1, saturating at 16'hFFFF.
REQ-026 Full FIFO with simultaneous push and pop: both SHALL succeed, fifo_count unchanged, no drop.
REQ-027 Empty FIFO with push and trace_ready=1: no pop (trace_valid=0), fifo_count becomes 1.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH.
REQ-029 instr_count SHALL increment on every push attempt (accepted or dropped), wrapping at 2^32.
REQ-030 retire_valid=1 with retire_instr=32'h0 (halt NOP) SHALL set halted next edge; NOP not pushed, not counted.
REQ-031 After halted=1: pushes, counters and watchdog SHALL freeze; pops SHALL continue until FIFO drains.
REQ-032 State machine SHALL be RUN -> HALT (NOP) or RUN -> TIMEOUT (watchdog); HALT and TIMEOUT exit only by reset.

Reset
REQ-033 reset=0 SHALL asynchronously clear pointers, fifo_count, instr_count, drop_count, idle counter, halted, timeout; state RUN.
REQ-034 trace_valid SHALL be 0 during and after reset; FIFO contents need not be cleared.
REQ-035 Reset mid-operation SHALL discard all queued records; first push after release SHALL land in entry 0.

Configuration
REQ-036 Macro TRACE_WATCHDOG_EN defined: idle counter increments each RUN cycle with retire_valid=0, clears on retire_valid=1; reaching WDOG_CYCLES SHALL set timeout=1 and halted=1 next edge.
REQ-037 Macro TRACE_WATCHDOG_EN undefined: no idle counter, timeout tied 0, TIMEOUT state absent.

Verification
REQ-038 Retire addi(0x00A00393)@pc 0, addi(0x01400413)@pc 4, trace_ready=1 -> two records, wdata 10 then 20, instr_count=2.
REQ-039 Retire sw (0x00702023), reg_write=0 -> record wdata=0, rd field as encoded, fifo_count 1 then 0.
REQ-040 DEPTH=8, trace_ready=0, 10 retires -> fifo_count=8, drop_count=2, first 8 records drained in order.
REQ-041 FIFO full, push and pop same cycle -> fifo_count stays 8, drop_count unchanged, order preserved across wrap.
REQ-042 Retire 3 instrs then instr 0 then 2 more -> halted=1, instr_count=3, exactly 3 records drained.
REQ-043 TRACE_WATCHDOG_EN, WDOG_CYCLES=16, no retires for 16 cycles -> timeout=1, halted=1; reset=0 pulse clears both.
